// File: rtl/sha_pad_ctrl.sv
// SHA-256 message padding and block sequencer: packs 32-bit message words into
// 512-bit blocks, appends the 0x80 marker and 64-bit length, and chains core results.
module sha_pad_ctrl #(
  parameter int CORE_SETTLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [1:0]   msg_last_bytes,
  output logic         first_state,
  output logic [255:0] initial_state,
  output logic [511:0] message_block,
  input  logic         status,
  input  logic [255:0] hash,
  input  logic         valid_block,
  output logic [255:0] digest,
  output logic         digest_valid
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, LAUNCH, SETTLE, WAIT_CORE, DONE} state_t;

  localparam logic [255:0] IV =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
  localparam logic [15:0] SETTLE_LAST = (CORE_SETTLE > 0) ? 16'(CORE_SETTLE - 1) : 16'd0;

  state_t            state;
  logic [15:0][31:0] blk_w;      // blk_w[15] is word 0
  logic [15:0][31:0] pad_blk;
  logic [3:0]        widx;
  logic [3:0]        mark_idx;   // word index holding (or due to hold) the 0x80 marker
  logic              mark_pend;  // marker word 0x80000000 still to be written at mark_idx
  logic              len_only;   // next PAD builds the zero block carrying only the length
  logic              final_blk;
  logic              ret_pad;
  logic [63:0]       bitcnt;
  logic [15:0]       settle_cnt;
  logic [255:0]      chain;

  logic        start;
  logic        accept;
  logic        full_last;
  logic        pad_final;
  logic [3:0]  cur_idx;
  logic [63:0] cnt_base;
  logic [5:0]  word_bits;
  logic [31:0] last_word;

  assign msg_ready     = (state == IDLE) || (state == FILL) || (state == DONE);
  assign accept        = msg_valid && msg_ready;
  assign start         = (state == IDLE) || (state == DONE);
  assign cur_idx       = start ? 4'd0 : widx;
  assign cnt_base      = start ? 64'd0 : bitcnt;
  assign full_last     = msg_last && (msg_last_bytes == 2'd0);
  assign message_block = blk_w;
  assign initial_state = chain;

  always_comb begin
    word_bits = 6'd32;
    if (msg_last && msg_last_bytes != 2'd0)
      word_bits = {1'b0, msg_last_bytes, 3'b000};
  end

  always_comb begin
    last_word = msg_data;
    case (msg_last_bytes)
      2'd1:    last_word = {msg_data[31:24], 8'h80, 16'h0000};
      2'd2:    last_word = {msg_data[31:16], 8'h80, 8'h00};
      2'd3:    last_word = {msg_data[31:8], 8'h80};
      default: last_word = msg_data;
    endcase
  end

  // Words past the marker are zeroed; the length goes in 14/15 only if the marker sits below 14.
  always_comb begin
    pad_blk   = blk_w;
    pad_final = len_only || (mark_idx < 4'd14);
    for (int j = 0; j < 16; j++) begin
      if (len_only) begin
        if (j == 14)      pad_blk[15-j] = bitcnt[63:32];
        else if (j == 15) pad_blk[15-j] = bitcnt[31:0];
        else              pad_blk[15-j] = 32'h0;
      end else if (mark_pend && 4'(j) == mark_idx) begin
        pad_blk[15-j] = 32'h8000_0000;
      end else if (4'(j) > mark_idx) begin
        if (j == 14)                          pad_blk[15-j] = bitcnt[63:32];
        else if (j == 15 && mark_idx < 4'd14) pad_blk[15-j] = bitcnt[31:0];
        else                                  pad_blk[15-j] = 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      blk_w        <= '0;
      widx         <= 4'd0;
      mark_idx     <= 4'd0;
      mark_pend    <= 1'b0;
      len_only     <= 1'b0;
      final_blk    <= 1'b0;
      ret_pad      <= 1'b0;
      bitcnt       <= 64'd0;
      settle_cnt   <= 16'd0;
      chain        <= IV;
      digest       <= '0;
      digest_valid <= 1'b0;
      first_state  <= 1'b0;
    end else begin
      first_state <= 1'b0;
      case (state)
        IDLE, FILL, DONE: begin
          if (accept) begin
            if (start) begin
              digest_valid <= 1'b0;
              chain        <= IV;
            end
            bitcnt <= cnt_base + 64'(word_bits);
            widx   <= cur_idx + 4'd1;
            if (!msg_last) begin
              blk_w[~cur_idx] <= msg_data;
              if (cur_idx == 4'd15) begin
                state       <= LAUNCH;
                first_state <= 1'b1;
                ret_pad     <= 1'b0;
                final_blk   <= 1'b0;
              end else begin
                state <= FILL;
              end
            end else begin
              blk_w[~cur_idx] <= last_word;
              len_only        <= 1'b0;
              if (!full_last) begin
                mark_idx  <= cur_idx;
                mark_pend <= 1'b0;
                state     <= PAD;
              end else begin
                // A full final word pushes the marker to the next index, maybe the next block.
                mark_idx  <= cur_idx + 4'd1;
                mark_pend <= 1'b1;
                if (cur_idx == 4'd15) begin
                  state       <= LAUNCH;
                  first_state <= 1'b1;
                  ret_pad     <= 1'b1;
                  final_blk   <= 1'b0;
                end else begin
                  state <= PAD;
                end
              end
            end
          end
        end
        PAD: begin
          blk_w       <= pad_blk;
          final_blk   <= pad_final;
          mark_pend   <= 1'b0;
          if (!pad_final) begin
            len_only <= 1'b1;
            ret_pad  <= 1'b1;
          end
          state       <= LAUNCH;
          first_state <= 1'b1;
        end
        LAUNCH: begin
          settle_cnt <= 16'd0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt >= SETTLE_LAST) state <= WAIT_CORE;
          else                           settle_cnt <= settle_cnt + 16'd1;
        end
        WAIT_CORE: begin
          if (status && valid_block) begin
            for (int i = 0; i < 8; i++)
              chain[32*i +: 32] <= hash[255-32*i -: 32];
            if (final_blk) begin
              digest       <= hash;
              digest_valid <= 1'b1;
              state        <= DONE;
            end else begin
              state <= ret_pad ? PAD : FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_pad_ctrl.sv
// Bench for sha_pad_ctrl: behavioural SHA-256 core plus a reference padder/hasher
// operating on byte queues.
module tb_sha_pad_ctrl;

  typedef logic [7:0]   bq_t [$];
  typedef logic [511:0] blkq_t [$];

  localparam logic [255:0] IV_H =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV_I =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset_n;
  logic         msg_valid, msg_ready, msg_last;
  logic [31:0]  msg_data;
  logic [1:0]   msg_last_bytes;
  logic         first_state, status, valid_block, digest_valid;
  logic [255:0] initial_state, hash, digest;
  logic [511:0] message_block;

  int n_cmp = 0;
  int n_bad = 0;
  int core_lat = 3;
  int busy_rdy = 0;
  int stab_err = 0;
  logic         core_busy;
  int           core_cnt;
  logic [255:0] core_res, cap_init;
  logic [511:0] cap_blk;
  logic [511:0] lblk [$];
  logic [255:0] linit [$];

  always #5 clk = ~clk;

  sha_pad_ctrl #(.CORE_SETTLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_last(msg_last), .msg_last_bytes(msg_last_bytes),
    .first_state(first_state), .initial_state(initial_state), .message_block(message_block),
    .status(status), .hash(hash), .valid_block(valid_block),
    .digest(digest), .digest_valid(digest_valid));

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic logic [255:0] to_hfmt(input logic [255:0] s);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = s[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] to_ifmt(input logic [255:0] h);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = h[255-32*i -: 32];
    return r;
  endfunction

  // Textbook SHA-256 padding of a byte string, cut into 512-bit blocks.
  function automatic blkq_t pad_msg(input bq_t m);
    bq_t p;
    blkq_t r;
    logic [63:0] len;
    logic [511:0] b;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
    for (int c = 0; c < p.size() / 64; c++) begin
      for (int k = 0; k < 64; k++) b[511-8*k -: 8] = p[64*c+k];
      r.push_back(b);
    end
    return r;
  endfunction

  // Behavioural hash core: busy for core_lat cycles after each launch.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status <= 1'b1; valid_block <= 1'b0; core_busy <= 1'b0; hash <= '0; core_cnt <= 0;
    end else if (first_state) begin
      core_busy <= 1'b1; status <= 1'b0; valid_block <= 1'b0; core_cnt <= core_lat;
      core_res  <= sha_comp(to_hfmt(initial_state), message_block);
      cap_blk   <= message_block;
      cap_init  <= initial_state;
    end else if (core_busy) begin
      if (core_cnt <= 1) begin
        core_busy <= 1'b0; status <= 1'b1; valid_block <= 1'b1; hash <= core_res;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && first_state) begin
      lblk.push_back(message_block);
      linit.push_back(initial_state);
    end
    if (core_busy && msg_ready) busy_rdy <= busy_rdy + 1;
    if (core_busy && (message_block !== cap_blk || initial_state !== cap_init)) stab_err <= stab_err + 1;
  end

  task automatic run_msg(input bq_t m, input int gap_max, input string nm, output logic [255:0] dg);
    blkq_t exp;
    logic [255:0] h;
    logic [31:0] d;
    int base, brd0, stab0, nw, t, nl, idx;
    exp = pad_msg(m);
    base = lblk.size(); brd0 = busy_rdy; stab0 = stab_err;
    nw = (m.size() + 3) / 4;
    dg = '0;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 4; b++) begin
        idx = 4*w + b;
        d[31-8*b -: 8] = (idx < m.size()) ? m[idx] : 8'($urandom);
      end
      if (gap_max > 0) begin
        msg_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      msg_valid = 1'b1; msg_data = d; msg_last = (w == nw - 1);
      msg_last_bytes = (w == nw - 1) ? 2'(m.size() % 4) : 2'($urandom);
      t = 0;
      while (!msg_ready && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) begin
        n_cmp++; n_bad++;
        $display("FAIL %s word_accept_timeout: msg_ready stayed 0 for word %0d", nm, w);
        msg_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (w == 0) begin
        n_cmp++;
        if (digest_valid !== 1'b0) begin
          n_bad++; $display("FAIL %s dv_clear_on_start: got %b expected 0", nm, digest_valid);
        end
      end
    end
    msg_valid = 1'b0; msg_last = 1'b0;
    t = 0;
    while (!digest_valid && t < 20000) begin @(negedge clk); t++; end
    n_cmp++;
    if (digest_valid !== 1'b1) begin
      n_bad++; $display("FAIL %s digest_valid_timeout: got %b expected 1", nm, digest_valid);
    end
    dg = digest;
    h = IV_H;
    for (int i = 0; i < exp.size(); i++) h = sha_comp(h, exp[i]);
    n_cmp++;
    if (digest !== h) begin
      n_bad++; $display("FAIL %s digest: got %h expected %h", nm, digest, h);
    end
    nl = lblk.size() - base;
    n_cmp++;
    if (nl !== exp.size()) begin
      n_bad++; $display("FAIL %s launch_count: got %0d expected %0d", nm, nl, exp.size());
    end
    h = IV_H;
    for (int i = 0; i < exp.size() && i < nl; i++) begin
      n_cmp++;
      if (lblk[base+i] !== exp[i]) begin
        n_bad++; $display("FAIL %s block%0d: got %h expected %h", nm, i, lblk[base+i], exp[i]);
      end
      n_cmp++;
      if (linit[base+i] !== to_ifmt(h)) begin
        n_bad++; $display("FAIL %s init%0d: got %h expected %h", nm, i, linit[base+i], to_ifmt(h));
      end
      h = sha_comp(h, exp[i]);
    end
    n_cmp++;
    if (busy_rdy - brd0 !== 0) begin
      n_bad++; $display("FAIL %s ready_while_busy: got %0d cycles expected 0", nm, busy_rdy - brd0);
    end
    n_cmp++;
    if (stab_err - stab0 !== 0) begin
      n_bad++; $display("FAIL %s block_stability: got %0d changes expected 0", nm, stab_err - stab0);
    end
  endtask

  function automatic bq_t rand_msg(input int len);
    bq_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  function automatic bq_t abc_msg();
    bq_t m;
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    return m;
  endfunction

  task automatic check_idle_outputs(input string nm);
    n_cmp++;
    if ({msg_ready, first_state, digest_valid} !== 3'b100) begin
      n_bad++; $display("FAIL %s ctrl: got rdy/fs/dv=%b expected 100", nm, {msg_ready, first_state, digest_valid});
    end
    n_cmp++;
    if (digest !== 256'd0 || message_block !== 512'd0) begin
      n_bad++; $display("FAIL %s data_zero: got digest %h block %h expected 0", nm, digest, message_block);
    end
    n_cmp++;
    if (initial_state !== IV_I) begin
      n_bad++; $display("FAIL %s iv: got %h expected %h", nm, initial_state, IV_I);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; msg_valid = 1'b1; msg_data = 32'hdeadbeef; msg_last = 1'b1; msg_last_bytes = 2'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    msg_valid = 1'b0; msg_last = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_abc();
    logic [255:0] dg;
    run_msg(abc_msg(), 0, "abc", dg);
    n_cmp++;
    if (dg !== 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD) begin
      n_bad++; $display("FAIL abc known_digest: got %h", dg);
    end
    n_cmp++;
    if (lblk[lblk.size()-1] !== {32'h61626380, 448'd0, 32'h18}) begin
      n_bad++; $display("FAIL abc known_block: got %h", lblk[lblk.size()-1]);
    end
  endtask

  task automatic test_two_block_56();
    bq_t m;
    logic [255:0] dg;
    for (int i = 0; i < 14; i++)
      for (int k = 0; k < 4; k++) m.push_back(8'(8'h61 + i + k));
    run_msg(m, 1, "msg56", dg);
    n_cmp++;
    if (dg !== 256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1) begin
      n_bad++; $display("FAIL msg56 known_digest: got %h", dg);
    end
    n_cmp++;
    if (lblk[lblk.size()-1] !== {480'd0, 32'h1C0}) begin
      n_bad++; $display("FAIL msg56 length_block: got %h", lblk[lblk.size()-1]);
    end
  endtask

  task automatic test_full_64();
    logic [255:0] dg;
    run_msg(rand_msg(64), 0, "msg64", dg);
    n_cmp++;
    if (lblk[lblk.size()-1] !== {32'h80000000, 448'd0, 32'h200}) begin
      n_bad++; $display("FAIL msg64 second_block: got %h", lblk[lblk.size()-1]);
    end
  endtask

  task automatic test_random();
    logic [255:0] dg;
    for (int n = 0; n < 10; n++) begin
      core_lat = $urandom_range(1, 6);
      run_msg(rand_msg($urandom_range(1, 150)), $urandom_range(0, 3), $sformatf("rand%0d", n), dg);
    end
    core_lat = 3;
  endtask

  task automatic test_backpressure();
    logic [255:0] dg;
    core_lat = 9;
    run_msg(rand_msg(71), 0, "backpressure", dg);
    core_lat = 3;
  endtask

  task automatic test_reset_mid();
    logic [255:0] dg;
    int base, t;
    core_lat = 12;
    base = lblk.size();
    for (int w = 0; w < 16; w++) begin
      msg_valid = 1'b1; msg_data = $urandom; msg_last = 1'b0;
      t = 0;
      while (!msg_ready && t < 100) begin @(negedge clk); t++; end
      @(posedge clk);
      @(negedge clk);
    end
    msg_valid = 1'b0;
    t = 0;
    while (!core_busy && t < 50) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (lblk.size() - base !== 1) begin
      n_bad++; $display("FAIL reset_mid launches: got %0d expected 1", lblk.size() - base);
    end
    core_lat = 3;
    run_msg(abc_msg(), 0, "abc_after_reset", dg);
    n_cmp++;
    if (dg !== 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD) begin
      n_bad++; $display("FAIL abc_after_reset known_digest: got %h", dg);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] dg;
    run_msg(rand_msg(23), 0, "b2b_first", dg);
    n_cmp++;
    if (digest_valid !== 1'b1 || msg_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b done_state: got dv/rdy=%b%b expected 11", digest_valid, msg_ready);
    end
    run_msg(rand_msg(60), 0, "b2b_second", dg);
  endtask

  initial begin
    reset_n = 1'b0; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_last_bytes = 2'd0;
    @(negedge clk);
    test_reset();
    test_abc();
    test_two_block_56();
    test_full_64();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
